// File: rtl/overlay_source.sv
// rtl/overlay_source.sv - overlay pixel supplier with memory prefetch and lookahead FIFO (optional OVERLAY_SOURCE_COLORKEY_EN)
module overlay_source #(
    parameter  int PIXEL_WIDTH = 8,
    parameter  int ALPHA_WIDTH = 8,
    parameter  int DIM_WIDTH   = 11,
    parameter  int ADDR_WIDTH  = 16,
    parameter  int FIFO_DEPTH  = 4,
    localparam int WORD_WIDTH  = 3*PIXEL_WIDTH+ALPHA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [DIM_WIDTH-1:0]     num_overlay_rows,
    input  logic [DIM_WIDTH-1:0]     num_overlay_cols,
    input  logic                     overlay_adv,
    input  logic                     overlay_restart,
`ifdef OVERLAY_SOURCE_COLORKEY_EN
    input  logic [3*PIXEL_WIDTH-1:0] colorkey,
`endif
    output logic [PIXEL_WIDTH-1:0]   overlay0,
    output logic [PIXEL_WIDTH-1:0]   overlay1,
    output logic [PIXEL_WIDTH-1:0]   overlay2,
    output logic [ALPHA_WIDTH-1:0]   overlayA,
    output logic                     mem_re,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [WORD_WIDTH-1:0]    mem_rdata,
    output logic                     underrun,
    input  logic                     underrun_clear
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;
    localparam int RW = 2 * DIM_WIDTH;

    logic [WORD_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
    logic [CW-1:0]         count_q, count_d;
    logic [RW-1:0]         remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_re_q, mem_re_d;
    logic                  pend_q, pend_d;
    logic                  underrun_q, underrun_d;
    logic                  push, pop, issue, urun_set;
    logic [OW-1:0]         occupancy;
    logic [WORD_WIDTH-1:0] head_word, next_word, pres_word;

    // Next-state: fetch issue, FIFO bookkeeping, restart flush and sticky underrun.
    // A read is outstanding while its strobe is on the bus (mem_re_q) and during
    // the following cycle when its data returns (pend_q); both reserve FIFO space.
    always_comb begin
        occupancy = OW'(count_q) + OW'(mem_re_q) + OW'(pend_q);
        push      = enable && !overlay_restart && pend_q;
        pop       = enable && !overlay_restart && overlay_adv && (count_q != '0);
        issue     = enable && !overlay_restart && (remaining_q != '0)
                    && (occupancy < OW'(FIFO_DEPTH));
        urun_set  = enable && !overlay_restart && overlay_adv && (count_q < CW'(2))
                    && ((remaining_q != '0) || mem_re_q || pend_q);

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        pend_d      = 1'b0;
        underrun_d  = underrun_q;

        if (!enable) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            remaining_d = '0;
            mem_addr_d  = '0;
        end else if (overlay_restart) begin
            // Outstanding reads die here: pend_d stays 0 so their data is never pushed.
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            mem_addr_d  = base_addr;
            remaining_d = RW'(num_overlay_rows) * RW'(num_overlay_cols);
        end else begin
            wr_ptr_d    = wr_ptr_q + PW'(push);
            rd_ptr_d    = rd_ptr_q + PW'(pop);
            count_d     = count_q + CW'(push) - CW'(pop);
            mem_re_d    = issue;
            mem_addr_d  = mem_addr_q + ADDR_WIDTH'(mem_re_q);
            remaining_d = remaining_q - RW'(issue);
            pend_d      = mem_re_q;
        end

        if (enable) begin
            if (urun_set) begin
                underrun_d = 1'b1;
            end else if (underrun_clear) begin
                underrun_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            pend_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            pend_q      <= pend_d;
            underrun_q  <= underrun_d;
        end
    end

    // FIFO storage; contents are meaningless outside count_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
        end
    end

    // Zero-latency presentation: with adv high the head is being popped, so show the one behind it.
    always_comb begin
        rd_ptr_nxt = rd_ptr_q + PW'(1);
        head_word  = fifo_q[rd_ptr_q];
        next_word  = fifo_q[rd_ptr_nxt];
        pres_word  = '0;
        if (!reset && enable && !overlay_restart) begin
            if (overlay_adv) begin
                if (count_q >= CW'(2)) begin
                    pres_word = next_word;
                end
            end else if (count_q != '0) begin
                pres_word = head_word;
            end
        end
`ifdef OVERLAY_SOURCE_COLORKEY_EN
        if (pres_word[3*PIXEL_WIDTH-1:0] == colorkey) begin
            pres_word[WORD_WIDTH-1 -: ALPHA_WIDTH] = '0;
        end
`endif
    end

    assign overlayA = pres_word[WORD_WIDTH-1 -: ALPHA_WIDTH];
    assign overlay2 = pres_word[3*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
    assign overlay1 = pres_word[2*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
    assign overlay0 = pres_word[PIXEL_WIDTH-1:0];
    assign mem_re   = mem_re_q;
    assign mem_addr = mem_addr_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_overlay_source.sv
// tb/tb_overlay_source.sv - scoreboard bench for overlay_source
module tb_overlay_source;

    logic        clk = 1'b0;
    logic        reset, enable, overlay_adv, overlay_restart, underrun_clear;
    logic [15:0] base_addr;
    logic [10:0] num_overlay_rows, num_overlay_cols;
    logic [7:0]  overlay0, overlay1, overlay2, overlayA;
    logic        mem_re, underrun;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
`ifdef OVERLAY_SOURCE_COLORKEY_EN
    logic [23:0] colorkey = 24'h00FF00;
`endif

    always #5 clk = ~clk;

    overlay_source dut (
        .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr),
        .num_overlay_rows(num_overlay_rows), .num_overlay_cols(num_overlay_cols),
        .overlay_adv(overlay_adv), .overlay_restart(overlay_restart),
`ifdef OVERLAY_SOURCE_COLORKEY_EN
        .colorkey(colorkey),
`endif
        .overlay0(overlay0), .overlay1(overlay1), .overlay2(overlay2), .overlayA(overlayA),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .underrun(underrun), .underrun_clear(underrun_clear)
    );

    wire [31:0] ovl = {overlayA, overlay2, overlay1, overlay0};

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc_n = 0;
    logic [31:0] sb[$];
    bit          take = 1'b0;
    logic [15:0] exp_rd_addr = '0;
    int          nreads = 0, npops = 0, max_occ = 0, first_rd = -1, last_rd = -1;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        if (a == 16'h0600) return 32'hFF00FF00;
        return {8'hFF, a[7:0] ^ 8'h5A, a[15:8], a[7:0]};
    endfunction

    function automatic logic [31:0] expect_px(input logic [31:0] w);
        logic [31:0] e;
        e = w;
`ifdef OVERLAY_SOURCE_COLORKEY_EN
        if (w[23:0] == colorkey) e[31:24] = 8'h00;
`endif
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Synchronous-read memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= word_at(mem_addr);
        cyc_n <= cyc_n + 1;
    end

    // Pixel monitor: a cycle with take=1 is one where the blender consumes the shown pixel.
    always @(negedge clk) begin
        if (take) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL pixel: got %h expected none (scoreboard empty)", ovl);
            end else begin
                check("pixel", ovl, sb.pop_front());
            end
        end
    end

    // Read monitor: addresses in order, and reads-in-flight plus FIFO never over depth.
    always @(negedge clk) begin
        if (mem_re) begin
            check("rd_addr", {16'h0, mem_addr}, {16'h0, exp_rd_addr});
            exp_rd_addr = exp_rd_addr + 16'd1;
            nreads++;
            if (first_rd < 0) first_rd = cyc_n;
            last_rd = cyc_n;
        end
        if (nreads - npops > max_occ) max_occ = nreads - npops;
        if (overlay_adv) npops++;
    end

    task automatic cyc(input bit t);
        @(posedge clk);
        #1;
        overlay_adv = take;
        take = t;
    endtask

    task automatic start_image(input logic [15:0] base, input logic [10:0] rows, input logic [10:0] cols);
        base_addr = base;
        num_overlay_rows = rows;
        num_overlay_cols = cols;
        cyc(0);
        overlay_restart = 1'b1;
        exp_rd_addr = base;
        nreads = 0;
        npops = 0;
        max_occ = 0;
        first_rd = -1;
    endtask

    task automatic run_image(input logic [15:0] base, input logic [10:0] rows,
                             input logic [10:0] cols, input int gap);
        int n;
        int rst_cyc;
        n = int'(rows) * int'(cols);
        start_image(base, rows, cols);
        rst_cyc = cyc_n;
        for (int k = 0; k < n; k++) sb.push_back(expect_px(word_at(base + 16'(k))));
        cyc(0);
        overlay_restart = 1'b0;
        repeat (8) cyc(0);
        for (int k = 0; k < n; k++) begin
            cyc(1);
            for (int g = 1; g < gap; g++) cyc(0);
        end
        repeat (4) cyc(0);
        @(negedge clk);
        check("reads_total", nreads, n);
        check("sb_drained", sb.size(), 0);
        check("occ_le_depth", 32'(max_occ <= 4), 1);
        check("no_underrun", {31'h0, underrun}, 0);
        check("tail_zero", ovl, 0);
        if (n > 0 && n <= 4) begin
            check("first_rd_latency", first_rd - rst_cyc, 2);
            check("rd_consecutive", last_rd - first_rd, n - 1);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; overlay_adv = 1'b0; overlay_restart = 1'b0;
        underrun_clear = 1'b0; base_addr = '0; num_overlay_rows = '0; num_overlay_cols = '0;
        cyc(0);
        cyc(0);
        @(negedge clk);
        check("rst_out", ovl, 0);
        check("rst_mem_re", {31'h0, mem_re}, 0);
        check("rst_mem_addr", {16'h0, mem_addr}, 0);
        check("rst_underrun", {31'h0, underrun}, 0);
        cyc(0);
        reset = 1'b0;
        enable = 1'b1;

        // 2x2 back-to-back, 3x5 sparse, address wrap
        run_image(16'h0100, 11'd2, 11'd2, 1);
        run_image(16'h0200, 11'd3, 11'd5, 3);
        run_image(16'hFFFF, 11'd1, 11'd2, 1);

        // zero-size overlay: no reads, adv must not raise underrun
        run_image(16'h0700, 11'd0, 11'd5, 1);
        cyc(0);
        overlay_adv = 1'b1;
        cyc(0);
        @(negedge clk);
        check("zero_size_no_urun", {31'h0, underrun}, 0);

        // underrun: adv arrives when only one pixel has landed
        start_image(16'h0300, 11'd1, 11'd4);
        cyc(0);
        overlay_restart = 1'b0;
        cyc(0);
        cyc(0);
        cyc(0);
        overlay_adv = 1'b1;
        @(negedge clk);
        check("urun_zero_out", ovl, 0);
        cyc(0);
        @(negedge clk);
        check("urun_set", {31'h0, underrun}, 1);
        cyc(0);
        enable = 1'b0;
        @(negedge clk);
        check("en0_out_zero", ovl, 0);
        cyc(0);
        @(negedge clk);
        check("en0_mem_re", {31'h0, mem_re}, 0);
        check("en0_mem_addr", {16'h0, mem_addr}, 0);
        check("en0_urun_held", {31'h0, underrun}, 1);
        cyc(0);
        enable = 1'b1;
        underrun_clear = 1'b1;
        cyc(0);
        underrun_clear = 1'b0;
        @(negedge clk);
        check("urun_cleared", {31'h0, underrun}, 0);

        // restart while FIFO holds 3 and a read's data is returning
        start_image(16'h0400, 11'd2, 11'd4);
        cyc(0);
        overlay_restart = 1'b0;
        repeat (4) cyc(0);
        @(negedge clk);
        check("pre_restart_head", ovl, expect_px(word_at(16'h0400)));
        start_image(16'h0500, 11'd1, 11'd2);
        @(negedge clk);
        check("restart_cycle_zero", ovl, 0);
        sb.push_back(expect_px(word_at(16'h0500)));
        sb.push_back(expect_px(word_at(16'h0501)));
        cyc(0);
        overlay_restart = 1'b0;
        @(negedge clk);
        check("flushed_zero", ovl, 0);
        repeat (6) cyc(0);
        cyc(1);
        cyc(1);
        repeat (3) cyc(0);
        @(negedge clk);
        check("rs_sb_drained", sb.size(), 0);
        check("rs_reads", nreads, 2);

`ifdef OVERLAY_SOURCE_COLORKEY_EN
        run_image(16'h0600, 11'd1, 11'd2, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
